// File: rtl/pokey_io_pkg.sv
// -----------------------------------------------------------------------------
// pokey_io_pkg
// Shared definitions for the POKEY IO block keyboard path: default parameter
// values, the keypad scan FSM state encoding and the encoding of the "no key"
// condition. Key results are carried as a presence flag plus a code. The flag
// says whether any key was seen, so every code value stays a real key index.
// -----------------------------------------------------------------------------
package pokey_io_pkg;

   localparam int DEF_NUM_ROWS   = 4;
   localparam int DEF_NUM_COLS   = 4;
   localparam int DEF_SCAN_DIV   = 64;
   localparam int DEF_DEBOUNCE   = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // rows undriven, waiting for scan_en
      ST_SCAN = 2'd1,   // one row driven low for SCAN_DIV cycles
      ST_EVAL = 2'd2    // one undriven cycle closing the frame
   } scan_state_e;

   // Presence flag of a key result. When the flag is KEY_NONE, the code that
   // goes with it is held at zero, so {flag, code} can be compared as a whole.
   localparam logic KEY_NONE = 1'b0;
   localparam logic KEY_SEEN = 1'b1;

endpackage

// File: rtl/key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
// Small synchronous FIFO holding keyboard codes.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears contents too)
//   push_i, data_i : write request and data
//   pop_i          : consume head; ignored when empty
//   data_o         : head entry
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored entries (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module key_fifo #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             pop_ok;
   logic             push_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A pop frees the slot the simultaneous push needs, so full does not block it.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the storage array is reset as well. A reset has to clear the
         // queue contents, and the head must read zero afterwards. That is cheap
         // at this depth. Non-blocking (<=) assignments are used throughout so
         // that every register samples the values from before the clock edge.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;  // DEPTH is a power of two: wraps
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/pokey_keyscan_fifo.sv
// -----------------------------------------------------------------------------
// pokey_keyscan_fifo
// This block scans a keypad matrix and debounces the key over whole frames.
// It queues key codes in a FIFO and raises the keyboard IRQ.
//   clk179, rst        : clock, synchronous active-high reset
//   scan_en            : enables scanning; low forces IDLE and forgets the key
//   row_drive_L        : one-hot-low row strobe, all ones when not scanning
//   col_in_L           : column returns (low = pressed), already synchronised
//   kb_code/kb_valid   : FIFO head and not-empty flag
//   kb_pop             : consume the head
//   kb_count           : FIFO occupancy
//   key_held_L         : low while a debounced key is held
//   overflow/ovf_clr   : sticky drop flag and its clear (set wins)
//   irq_en/irq_L       : IRQ enable; active-low pending status
// A frame is NUM_ROWS*SCAN_DIV cycles of row drive and one EVAL cycle.
// -----------------------------------------------------------------------------
module pokey_keyscan_fifo
   import pokey_io_pkg::*;
#(
   parameter  int NUM_ROWS   = DEF_NUM_ROWS,
   parameter  int NUM_COLS   = DEF_NUM_COLS,
   parameter  int SCAN_DIV   = DEF_SCAN_DIV,
   parameter  int DEBOUNCE   = DEF_DEBOUNCE,
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int CODE_W     = $clog2(NUM_ROWS*NUM_COLS),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk179,
   input  logic                rst,
   input  logic                scan_en,
   output logic [NUM_ROWS-1:0] row_drive_L,
   input  logic [NUM_COLS-1:0] col_in_L,
   output logic [CODE_W-1:0]   kb_code,
   output logic                kb_valid,
   input  logic                kb_pop,
   output logic [CNT_W-1:0]    kb_count,
   output logic                key_held_L,
   output logic                overflow,
   input  logic                ovf_clr,
   input  logic                irq_en,
   output logic                irq_L
);

   localparam int ROW_W   = $clog2(NUM_ROWS);
   localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DEB_W   = $clog2(DEBOUNCE + 1);

   localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(NUM_ROWS - 1);
   localparam logic [DWELL_W-1:0]  LAST_DWELL = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]    DEB_MAX    = DEB_W'(DEBOUNCE);
   localparam logic [NUM_ROWS-1:0] ROW0_L     = ~NUM_ROWS'(1);

   // ---------------------------------------------------------------- scan FSM
   scan_state_e         state_q;
   logic [ROW_W-1:0]    row_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic [NUM_ROWS-1:0] row_drive_q;

   always_ff @(posedge clk179) begin
      if (rst || !scan_en) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         dwell_q     <= '0;
         row_drive_q <= '1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q     <= ST_SCAN;
               row_q       <= '0;
               dwell_q     <= '0;
               row_drive_q <= ROW0_L;
            end
            ST_SCAN: begin
               if (dwell_q == LAST_DWELL) begin
                  dwell_q <= '0;
                  if (row_q == LAST_ROW) begin
                     state_q     <= ST_EVAL;
                     row_drive_q <= '1;
                  end else begin
                     row_q       <= row_q + 1'b1;
                     row_drive_q <= ~(NUM_ROWS'(1) << (row_q + 1'b1));
                  end
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            ST_EVAL: begin
               state_q     <= ST_SCAN;
               row_q       <= '0;
               dwell_q     <= '0;
               row_drive_q <= ROW0_L;
            end
            default: begin
               state_q     <= ST_IDLE;
               row_drive_q <= '1;
            end
         endcase
      end
   end

   assign row_drive_L = row_drive_q;

   // --------------------------------------------- frame result and debounce
   logic              found_q,    found_d;     // a key was seen this frame
   logic [CODE_W-1:0] fcode_q,    fcode_d;     // lowest key seen this frame
   logic              cand_v_q,   cand_v_d;
   logic [CODE_W-1:0] cand_c_q,   cand_c_d;
   logic [DEB_W-1:0]  cnt_q,      cnt_d;
   logic              stable_v_q, stable_v_d;
   logic [CODE_W-1:0] stable_c_q, stable_c_d;
   logic              event_q,    event_d;     // high in the push cycle
   logic [CODE_W-1:0] ev_code_q,  ev_code_d;   // code to push, held apart from
                                               // stable so a scan stop cannot
                                               // corrupt it

   logic              col_any;
   logic [COL_W-1:0]  col_idx;
   logic [CODE_W-1:0] hit_code;

   always_comb begin
      // NOTE: every variable gets a default before any condition. Otherwise
      // paths that do not assign it would infer latches.
      col_idx = '0;
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
         if (!col_in_L[c]) col_idx = COL_W'(c);  // descending loop: lowest wins
      end
   end

   assign col_any  = ~&col_in_L;
   assign hit_code = CODE_W'(row_q) * CODE_W'(NUM_COLS) + CODE_W'(col_idx);

   always_comb begin
      found_d    = found_q;
      fcode_d    = fcode_q;
      cand_v_d   = cand_v_q;
      cand_c_d   = cand_c_q;
      cnt_d      = cnt_q;
      stable_v_d = stable_v_q;
      stable_c_d = stable_c_q;
      event_d    = 1'b0;
      ev_code_d  = ev_code_q;

      // Rows are scanned in ascending order. The first hit in a frame is
      // therefore the lowest key index, and later hits are ignored.
      if (state_q == ST_SCAN && dwell_q == LAST_DWELL && !found_q && col_any) begin
         found_d = KEY_SEEN;
         fcode_d = hit_code;
      end

      if (state_q == ST_EVAL) begin
         if ({found_q, fcode_q} == {cand_v_q, cand_c_q}) begin
            if (cnt_q != DEB_MAX) cnt_d = cnt_q + 1'b1;
         end else begin
            cand_v_d = found_q;
            cand_c_d = fcode_q;
            cnt_d    = DEB_W'(1);
         end
         if (cnt_d == DEB_MAX && {cand_v_d, cand_c_d} != {stable_v_q, stable_c_q}) begin
            stable_v_d = cand_v_d;
            stable_c_d = cand_c_d;
            event_d    = (cand_v_d == KEY_SEEN);  // a release is not an event
            ev_code_d  = cand_c_d;
         end
         found_d = KEY_NONE;
         fcode_d = '0;
      end

      if (!scan_en) begin
         found_d    = KEY_NONE;
         fcode_d    = '0;
         cand_v_d   = KEY_NONE;
         cand_c_d   = '0;
         cnt_d      = '0;
         stable_v_d = KEY_NONE;
         stable_c_d = '0;
         event_d    = 1'b0;
      end
   end

   always_ff @(posedge clk179) begin
      if (rst) begin
         found_q    <= KEY_NONE;
         fcode_q    <= '0;
         cand_v_q   <= KEY_NONE;
         cand_c_q   <= '0;
         cnt_q      <= '0;
         stable_v_q <= KEY_NONE;
         stable_c_q <= '0;
         event_q    <= 1'b0;
         ev_code_q  <= '0;
      end else begin
         found_q    <= found_d;
         fcode_q    <= fcode_d;
         cand_v_q   <= cand_v_d;
         cand_c_q   <= cand_c_d;
         cnt_q      <= cnt_d;
         stable_v_q <= stable_v_d;
         stable_c_q <= stable_c_d;
         event_q    <= event_d;
         ev_code_q  <= ev_code_d;
      end
   end

   assign key_held_L = (stable_v_q == KEY_NONE);

   // ------------------------------------------------------- FIFO, overflow, IRQ
   logic fifo_full;
   logic fifo_empty;
   logic drop;

   key_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clk_i   (clk179),
      .rst_i   (rst),
      .push_i  (event_q),
      .data_i  (ev_code_q),
      .pop_i   (kb_pop),
      .data_o  (kb_code),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (kb_count)
   );

   assign kb_valid = ~fifo_empty;
   assign drop     = event_q & fifo_full & ~kb_pop;

   logic ovf_q;
   logic irq_pend_q;

   always_ff @(posedge clk179) begin
      if (rst) begin
         ovf_q      <= 1'b0;
         irq_pend_q <= 1'b0;
      end else begin
         if (drop)         ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;

         // A dropped event still requests the interrupt; disable has priority.
         if (!irq_en)      irq_pend_q <= 1'b0;
         else if (event_q) irq_pend_q <= 1'b1;
      end
   end

   assign overflow = ovf_q;
   assign irq_L    = ~irq_pend_q;

endmodule

// File: tb/tb_pokey_keyscan_fifo.sv
// -----------------------------------------------------------------------------
// tb_pokey_keyscan_fifo
// The bench is frame-oriented. A key set is held for each whole frame, and the
// column returns come from a simple matrix model driven by the row strobes.
// The reference keeps a history of frame results, a queue for the FIFO, and
// flags for overflow and the IRQ.
// -----------------------------------------------------------------------------
module tb_pokey_keyscan_fifo;

   localparam int NR = 4;
   localparam int NC = 4;
   localparam int SD = 64;
   localparam int DB = 4;
   localparam int FD = 4;

   logic          clk179 = 1'b0;
   logic          rst;
   logic          scan_en;
   logic [NR-1:0] row_drive_L;
   logic [NC-1:0] col_in_L;
   logic [3:0]    kb_code;
   logic          kb_valid;
   logic          kb_pop;
   logic [2:0]    kb_count;
   logic          key_held_L;
   logic          overflow;
   logic          ovf_clr;
   logic          irq_en;
   logic          irq_L;

   logic [NR*NC-1:0] keys;

   int total = 0;
   int bad   = 0;

   // reference state
   int hist[$];
   int stable_m;
   bit ev_m;
   int ev_code_m;
   int fifo_m[$];
   bit ovf_m;
   bit irq_m;

   pokey_keyscan_fifo #(
      .NUM_ROWS   (NR),
      .NUM_COLS   (NC),
      .SCAN_DIV   (SD),
      .DEBOUNCE   (DB),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk179      (clk179),
      .rst         (rst),
      .scan_en     (scan_en),
      .row_drive_L (row_drive_L),
      .col_in_L    (col_in_L),
      .kb_code     (kb_code),
      .kb_valid    (kb_valid),
      .kb_pop      (kb_pop),
      .kb_count    (kb_count),
      .key_held_L  (key_held_L),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr),
      .irq_en      (irq_en),
      .irq_L       (irq_L)
   );

   always #5 clk179 = ~clk179;

   // Passive key matrix: a pressed key shorts its row strobe onto its column.
   always_comb begin
      col_in_L = '1;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < NC; c++) begin
            if (!row_drive_L[r] && keys[r*NC+c]) col_in_L[c] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk179);
      #1;
   endtask

   function automatic int lowest(input logic [15:0] m);
      for (int i = 0; i < 16; i++) begin
         if (m[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      hist.delete();
      fifo_m.delete();
      stable_m  = -1;
      ev_m      = 1'b0;
      ev_code_m = 0;
      ovf_m     = 1'b0;
      irq_m     = 1'b0;
   endfunction

   // A stable key changes once the last DB frame results agree and differ from it.
   function automatic void model_eval(input logic [15:0] m);
      int  res;
      bit  same;
      res = lowest(m);
      hist.push_back(res);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
         same = 1'b1;
         foreach (hist[i]) if (hist[i] != res) same = 1'b0;
         if (same && res != stable_m) begin
            stable_m = res;
            if (res >= 0) begin
               ev_m      = 1'b1;
               ev_code_m = res;
            end
         end
      end
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".valid"}, kb_valid, fifo_m.size() > 0);
      check({tag, ".count"}, kb_count, fifo_m.size());
      if (fifo_m.size() > 0) check({tag, ".code"}, kb_code, fifo_m[0]);
      check({tag, ".held_L"}, key_held_L, stable_m < 0);
      check({tag, ".ovf"}, overflow, ovf_m);
      check({tag, ".irq_L"}, irq_L, !irq_m);
   endtask

   // One frame, starting right after an EVAL edge (the push cycle of any event
   // found there). abort: 0 none, 1 drop scan_en mid-frame, 2 reset mid-frame.
   task automatic run_frame(input logic [15:0] m, input bit ie, input bit pop_push,
                            input bit pop_mid, input bit clr_push, input int abort);
      int n;
      bit popok;
      bit dropped;
      keys    = m;
      irq_en  = ie;
      kb_pop  = pop_push;
      ovf_clr = clr_push;

      popok   = pop_push && fifo_m.size() > 0;
      dropped = 1'b0;
      if (popok) void'(fifo_m.pop_front());
      if (ev_m) begin
         if (fifo_m.size() < FD) fifo_m.push_back(ev_code_m);
         else dropped = 1'b1;
      end
      if (dropped)       ovf_m = 1'b1;
      else if (clr_push) ovf_m = 1'b0;
      if (!ie)           irq_m = 1'b0;
      else if (ev_m)     irq_m = 1'b1;
      ev_m = 1'b0;

      step();
      kb_pop  = 1'b0;
      ovf_clr = 1'b0;
      step();
      n = 2;
      check_state("frame");
      check("rows.r0", row_drive_L, 4'b1110);

      if (pop_mid) begin
         kb_pop = 1'b1;
         if (fifo_m.size() > 0) void'(fifo_m.pop_front());
         step();
         kb_pop = 1'b0;
         n++;
         check("pop.count", kb_count, fifo_m.size());
         check("pop.irq_L", irq_L, !irq_m);
      end

      while (n < 100) begin
         step();
         n++;
      end
      check("rows.r1", row_drive_L, 4'b1101);

      if (abort == 1) begin
         scan_en = 1'b0;
         step();
         hist.delete();
         stable_m = -1;
         check("stop.rows", row_drive_L, 4'b1111);
         check_state("stop");
         scan_en = 1'b1;
         step();
         check("restart.rows", row_drive_L, 4'b1110);
         return;
      end
      if (abort == 2) begin
         rst = 1'b1;
         step();
         rst = 1'b0;
         model_reset();
         check("mrst.rows", row_drive_L, 4'b1111);
         check("mrst.code", kb_code, 0);
         check_state("mrst");
         step();
         return;
      end

      while (n < 256) begin
         step();
         n++;
      end
      check("rows.eval", row_drive_L, 4'b1111);
      step();
      model_eval(m);
   endtask

   initial begin
      logic [15:0] m;
      int          hold;

      rst     = 1'b1;
      scan_en = 1'b1;
      irq_en  = 1'b0;
      kb_pop  = 1'b0;
      ovf_clr = 1'b0;
      keys    = '0;
      model_reset();

      // reset
      step();
      check("rst.rows0", row_drive_L, 4'b1111);
      step();
      check("rst.rows1", row_drive_L, 4'b1111);
      check("rst.code", kb_code, 0);
      check_state("rst");
      rst = 1'b0;
      step();
      check("start.rows", row_drive_L, 4'b1110);

      // single press of key 6, popped in the fifth frame
      repeat (4) run_frame(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      repeat (4) run_frame(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      // bounce: 3 on, 1 off, 3 on gives nothing; a 4th on gives one push
      repeat (3) run_frame(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      repeat (4) run_frame(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      // keys 9 and 3 together, then 3 released
      repeat (4) run_frame(16'h0208, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0200, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      repeat (4) run_frame(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);

      // overflow: five key events with no pop
      repeat (4) run_frame(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0080, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      repeat (4) run_frame(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      // push of key 8 meets a pop while full
      run_frame(16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      // drop and clear in the same cycle: the drop wins
      repeat (4) run_frame(16'h0400, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0400, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      run_frame(16'h0400, 1'b1, 1'b0, 1'b0, 1'b1, 0);

      // IRQ disabled: codes are still queued but no interrupt is raised
      repeat (4) run_frame(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      repeat (4) run_frame(16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // randomised key activity
      for (int seg = 0; seg < 30; seg++) begin
         case ($urandom_range(0, 3))
            0:       m = 16'h0000;
            1:       m = 16'h0001 << $urandom_range(0, 15);
            2:       m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default: m = 16'($urandom) & 16'($urandom) & 16'($urandom);
         endcase
         hold = $urandom_range(1, 6);
         for (int f = 0; f < hold; f++) begin
            run_frame(m, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 0);
         end
      end

      // scan_en dropped mid-frame while a key is held
      repeat (5) run_frame(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      repeat (2) run_frame(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      // reset mid-operation with entries queued
      repeat (5) run_frame(16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_frame(16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 2);
      repeat (2) run_frame(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pokey_keyscan_fifo.md
Name: pokey_keyscan_fifo

Overview:
Parametrised successor to the POKEY keypad/IRQ path: scans an NUM_ROWS x NUM_COLS active-low key matrix and debounces the result over whole scan frames. Buffers key-press codes in a small FIFO and raises the keyboard IRQ status bit. It sits in the POKEY IO block between the controller header pins and the KBCODE/SKSTAT/IRQST register bus.

Parameters:
NUM_ROWS, 4, number of driven scan lines (>=2)
NUM_COLS, 4, number of sensed return lines (>=1)
SCAN_DIV, 64, clk179 cycles each row is driven (dwell, >=2)
DEBOUNCE, 4, consecutive identical frame results required to change the stable key (>=1)
FIFO_DEPTH, 4, key-code FIFO entries (power of 2, >=2)
Localparam CODE_W = $clog2(NUM_ROWS*NUM_COLS).

Ports:
clk179  in  1  system clock; sole clock
rst  in  1  reset, synchronous, active-high
scan_en  in  1  1 = scanning (SKCTL[1] equivalent)
row_drive_L  out  NUM_ROWS  one-hot-low row drive; all ones when idle
col_in_L  in  NUM_COLS  matrix returns, low = pressed; pre-synchronised
kb_code  out  CODE_W  FIFO head code (row*NUM_COLS+col)
kb_valid  out  1  FIFO not empty
kb_pop  in  1  one-cycle strobe: consume head
kb_count  out  $clog2(FIFO_DEPTH)+1  occupancy
key_held_L  out  1  low while stable key present (SKSTAT[2] style)
overflow  out  1  sticky: key event dropped because FIFO was full
ovf_clr  in  1  clears overflow
irq_en  in  1  IRQEN[6]; 0 clears and blocks the pending IRQ
irq_L  out  1  active-low keyboard IRQ status (IRQST[6])

Behaviour:
- Reset values: row_drive_L = all 1, kb_valid = 0, kb_count = 0, kb_code = 0, key_held_L = 1, overflow = 0, irq_L = 1. Stable key = NONE; debounce count = 0; FSM = IDLE.
- FSM states:
  - IDLE: rows undriven.
  - IDLE -> SCAN (row 0, dwell counter 0) when scan_en = 1.
  - SCAN: drive row r low. On the last dwell cycle (counter = SCAN_DIV-1), sample col_in_L. Then go to r+1, or to EVAL after the last row.
  - EVAL: one cycle with rows undriven. Computes the frame result, then returns to SCAN with row 0.
- Frame length = NUM_ROWS*SCAN_DIV + 1 cycles (257 at defaults).
- Frame result: lowest index of any sampled pressed key; NONE if no key was pressed. Multiple presses resolve to the lowest index only.
- Debounce, evaluated in EVAL:
  - If result = candidate, the count increments, saturating at DEBOUNCE; otherwise candidate <= result and count <= 1.
  - When count reaches DEBOUNCE and candidate != stable, stable <= candidate.
  - If the new stable value is a key, this is a key event.
  - Release to NONE is not an event.
  - A key-to-different-key change is an event.
- key_held_L = (stable == NONE).
- Key event: push the code in the cycle after EVAL. kb_valid rises the following cycle.
- FIFO rules:
  - Full with no pop: the code is dropped and overflow is set.
  - Full with pop in the same cycle: both happen, no overflow.
  - Pop when empty: ignored.
  - ovf_clr and a new drop in the same cycle: set wins.
- IRQ:
  - irq pending is set on every key event, including dropped ones, only while irq_en = 1.
  - irq_en = 0 clears it synchronously.
  - irq_en falling in the same cycle as an event: the clear wins.
  - irq_L = ~pending. Popping does not clear the IRQ.
- scan_en falling mid-frame: next cycle enter IDLE, rows all 1, stable = NONE, candidate/count cleared. FIFO, overflow and IRQ are retained. Re-enable restarts at row 0.
- rst mid-operation: everything returns to reset values, including the FIFO contents.

Decomposition:
- Shared package pokey_io_pkg:
  - scan-state enum (IDLE, SCAN, EVAL);
  - NONE code encoding (an extra valid flag, not a code value);
  - default parameter constants.
- Sub-module key_fifo: synchronous FIFO parameterised on width/depth with push, pop, full, empty, count, and the simultaneous-push/pop-when-full rule.

Test Plan:
- Reset: rst = 1 for 2 cycles, scan_en = 1 -> row_drive_L = 4'b1111 during reset; then 4'b1110 for 64 cycles, 4'b1101 next; irq_L = 1, kb_valid = 0.
- Single press: col_in_L[2] low whenever row 1 is driven, irq_en = 1 -> after the 4th EVAL (cycle 1028 after scan start) push code 6. kb_valid = 1 and kb_code = 6 one cycle later; irq_L = 0; key_held_L = 0. kb_pop -> kb_count = 0 while irq_L stays 0.
- Bounce: key 6 present 3 frames, absent 1, present 3 -> no push; present a 4th consecutive frame -> exactly one push.
- Two keys 9 and 3 held together -> code 3 pushed; release of 3 while 9 is held (4 frames) -> code 9 pushed.
- Overflow: 5 distinct key events without pop -> kb_count = 4, overflow = 1, head = first code. Event with simultaneous pop when full -> overflow unchanged, count stays 4.
- irq_en = 0 during an event -> irq_L stays 1 but code is still pushed. scan_en dropped mid-frame -> rows all 1 and key_held_L = 1 next cycle, FIFO intact.
